// File: rtl/alu_instr_dispatcher_if.sv
// Instruction-source and ALU-FSM handshake bundle for alu_instr_dispatcher.
// slave: dispatcher view; master: the surrounding source/ALU view.
interface alu_instr_dispatcher_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned REGW = 6
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [OPW+2*REGW-1:0]  instr_word;
  logic                   start;
  logic [OPW-1:0]         opCode;
  logic [REGW-1:0]        Ri;
  logic [REGW-1:0]        Rj;
  logic                   done;

  modport master (
    output instr_valid, instr_word, done,
    input  instr_ready, start, opCode, Ri, Rj
  );

  modport slave (
    input  instr_valid, instr_word, done,
    output instr_ready, start, opCode, Ri, Rj
  );
endinterface

// File: rtl/alu_instr_dispatcher.sv
// Buffers packed instruction words and issues them in order to the ALU FSM.
// Optional WATCHDOG_EN macro adds a WAIT-state timeout that drops a stuck instruction.
module alu_instr_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OPW     = 4,
  parameter int unsigned REGW    = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  alu_instr_dispatcher_if.slave      bus_io,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic [15:0]                issued_count_o,
  output logic                       err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = OPW + 2 * REGW;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : gen_param_check
    $error("alu_instr_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  // FIFO storage and bookkeeping
  logic [WW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  state_e          state_q;
  logic            start_q;
  logic            busy_q;
  logic [OPW-1:0]  op_q;
  logic [REGW-1:0] ri_q;
  logic [REGW-1:0] rj_q;
  logic [15:0]     issued_q;

  assign bus_io.instr_ready = (count_q != FullCount);
  assign push = bus_io.instr_valid && bus_io.instr_ready;
  assign pop  = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.instr_word;
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  logic [WdW-1:0] wd_cnt_q;
  logic           err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      op_q     <= '0;
      ri_q     <= '0;
      rj_q     <= '0;
      issued_q <= '0;
`ifdef WATCHDOG_EN
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            {op_q, ri_q, rj_q} <= mem_q[rd_ptr_q];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          start_q <= 1'b0;
          state_q <= StWait;
`ifdef WATCHDOG_EN
          wd_cnt_q <= '0;
`endif
        end
        StWait: begin
          // done wins over a timeout landing in the same cycle
          if (bus_io.done) begin
            busy_q   <= 1'b0;
            issued_q <= issued_q + 16'd1;
            state_q  <= StIdle;
          end
`ifdef WATCHDOG_EN
          else if (wd_cnt_q == WdLast) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.start  = start_q;
  assign bus_io.opCode = op_q;
  assign bus_io.Ri     = ri_q;
  assign bus_io.Rj     = rj_q;
  assign busy_o         = busy_q;
  assign fifo_count_o   = count_q;
  assign issued_count_o = issued_q;
`ifdef WATCHDOG_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_instr_dispatcher.sv
// Scoreboard bench for alu_instr_dispatcher: pushes enqueue expected issues, a monitor
// pops and compares on every start pulse.
module tb_alu_instr_dispatcher;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned OPW     = 4;
  localparam int unsigned REGW    = 6;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned WW      = OPW + 2 * REGW;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            issued_count;
  logic                   err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WW-1:0] exp_q[$];

  alu_instr_dispatcher_if #(.OPW(OPW), .REGW(REGW)) bus ();

  alu_instr_dispatcher #(
    .DEPTH(DEPTH), .OPW(OPW), .REGW(REGW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .bus_io         (bus),
    .busy_o         (busy),
    .fifo_count_o   (fifo_count),
    .issued_count_o (issued_count),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Present a word for one cycle; queue it only if the FIFO was ready.
  task automatic push_word(input logic [WW-1:0] w);
    logic acc;
    bus.instr_valid = 1'b1;
    bus.instr_word  = w;
    acc = bus.instr_ready;
    tick();
    if (acc) exp_q.push_back(w);
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int i;
    i = 0;
    while (!bus.start && i < 20) begin
      tick();
      i++;
    end
    n_checks++;
    if (!bus.start) begin
      n_fail++;
      $display("FAIL %s: got no start within 20 cycles, required start", name);
    end
  endtask

  task automatic complete_one(input string name);
    wait_start(name);
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.done = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: order, single-cycle start, no overlap, operand hold.
  logic          prev_start = 1'b0;
  logic          prev_busy  = 1'b0;
  logic [WW-1:0] held = '0;
  logic [WW-1:0] w_exp;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.start) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_unexpected: got word 0x%0h, required no start",
                   {bus.opCode, bus.Ri, bus.Rj});
        end else begin
          w_exp = exp_q.pop_front();
          if ({bus.opCode, bus.Ri, bus.Rj} !== w_exp) begin
            n_fail++;
            $display("FAIL issue_order: got 0x%0h, required 0x%0h",
                     {bus.opCode, bus.Ri, bus.Rj}, w_exp);
          end
        end
        n_checks++;
        if (prev_start || prev_busy) begin
          n_fail++;
          $display("FAIL start_overlap: got prev_start=%0b prev_busy=%0b, required 0/0",
                   prev_start, prev_busy);
        end
        held <= {bus.opCode, bus.Ri, bus.Rj};
      end else if (busy) begin
        n_checks++;
        if ({bus.opCode, bus.Ri, bus.Rj} !== held) begin
          n_fail++;
          $display("FAIL operand_hold: got 0x%0h, required 0x%0h",
                   {bus.opCode, bus.Ri, bus.Rj}, held);
        end
      end
    end
    prev_start <= bus.start;
    prev_busy  <= busy;
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_word  = '0;
    bus.done        = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_start", bus.start, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_issued", issued_count, 0);
    check("rst_err", err, 0);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_operands", {bus.opCode, bus.Ri, bus.Rj}, 0);

    // Basic issue
    push_word(16'h10C3);
    check("basic_no_start_e0", bus.start, 0);
    check("basic_count", fifo_count, 1);
    tick();
    check("basic_start_e1", bus.start, 1);
    check("basic_busy", busy, 1);
    check("basic_op", bus.opCode, 1);
    check("basic_ri", bus.Ri, 3);
    check("basic_rj", bus.Rj, 3);
    tick();
    check("basic_start_low", bus.start, 0);
    repeat (3) tick();
    check("basic_busy_wait", busy, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("basic_busy_fall", busy, 0);
    check("basic_issued", issued_count, 1);
    check("basic_op_kept", bus.opCode, 1);

    // Ordering and full
    do_reset();
    push_word(16'h1003);
    push_word(16'h2041);
    push_word(16'h3082);
    push_word(16'h40C0);
    check("full_count3", fifo_count, 3);
    push_word(16'h5104);
    check("full_count4", fifo_count, 4);
    check("full_ready0", bus.instr_ready, 0);
    push_word(16'h6145);
    check("full_refused", fifo_count, 4);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    for (int i = 0; i < 4; i++) complete_one("full_drain");
    check("full_issued", issued_count, 5);
    check("full_empty", fifo_count, 0);
    check("full_sb_empty", exp_q.size(), 0);

    // Simultaneous push and pop
    do_reset();
    push_word(16'h7185);
    push_word(16'h81C6);
    push_word(16'h9207);
    check("pp_count2", fifo_count, 2);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    push_word(16'hA248);
    check("pp_count_same", fifo_count, 2);
    check("pp_start", bus.start, 1);
    for (int i = 0; i < 3; i++) complete_one("pp_drain");
    check("pp_issued", issued_count, 4);
    check("pp_sb_empty", exp_q.size(), 0);

    // Spurious done
    do_reset();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("spur_idle_issued", issued_count, 0);
    check("spur_idle_busy", busy, 0);
    push_word(16'hB289);
    bus.done = 1'b1;
    tick();
    check("spur_issue_start", bus.start, 1);
    tick();
    bus.done = 1'b0;
    check("spur_issue_busy", busy, 1);
    check("spur_issue_issued", issued_count, 0);
    tick();
    check("spur_wait_busy", busy, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("spur_done_issued", issued_count, 1);
    check("spur_done_busy", busy, 0);

    // Reset mid-WAIT
    do_reset();
    push_word(16'hC2CA);
    push_word(16'hD30B);
    push_word(16'hE34C);
    push_word(16'hF38D);
    check("rw_count3", fifo_count, 3);
    check("rw_busy", busy, 1);
    do_reset();
    check("rw_busy0", busy, 0);
    check("rw_count0", fifo_count, 0);
    check("rw_start0", bus.start, 0);
    check("rw_operands0", {bus.opCode, bus.Ri, bus.Rj}, 0);
    check("rw_ready", bus.instr_ready, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("rw_late_done", issued_count, 0);
    repeat (5) tick();
    check("rw_no_start", bus.start, 0);
    push_word(16'h23CE);
    complete_one("rw_new");
    check("rw_new_issued", issued_count, 1);

    // Watchdog
    do_reset();
    push_word(16'h340F);
    push_word(16'h4450);
    wait_start("wd_first");
    tick();
`ifdef WATCHDOG_EN
    repeat (7) tick();
    check("wd_err_before", err, 0);
    tick();
    check("wd_err", err, 1);
    check("wd_busy", busy, 0);
    check("wd_issued", issued_count, 0);
    tick();
    check("wd_next_start", bus.start, 1);
    complete_one("wd_next");
    check("wd_issued_after", issued_count, 1);
    check("wd_err_sticky", err, 1);
`else
    repeat (100) tick();
    check("nowd_err", err, 0);
    check("nowd_busy", busy, 1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    complete_one("nowd_next");
    check("nowd_issued", issued_count, 2);
`endif
    check("final_sb_empty", exp_q.size(), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
